// File: rtl/conv1_pool_feeder.sv
// conv1 -> max-pool window producer. Even rows are parked in a line buffer; while the
// following odd row streams in, aligned 2-row windows of NUM_PIXELS_BUF pixels are emitted.
module conv1_pool_feeder #(
    parameter int NUM_FILT       = 6,
    parameter int OPERAND_WDTH   = 22,
    parameter int NUM_PIXELS_BUF = 4,
    parameter int ROW_LEN        = 28,
    parameter int NUM_ROWS       = 28
) (
    input  logic                                             conv1_feed_clk,
    input  logic                                             conv1_feed_rst_b,
    input  logic                                             feed_in_valid_i,
    output logic                                             feed_in_ready_o,
    input  logic [NUM_FILT*OPERAND_WDTH-1:0]                 feed_in_pix_i,
    output logic                                             feed_out_valid_o,
    input  logic                                             feed_out_ready_i,
    output logic [NUM_FILT*NUM_PIXELS_BUF*OPERAND_WDTH-1:0]  feed_pool_a_o,
    output logic [NUM_FILT*NUM_PIXELS_BUF*OPERAND_WDTH-1:0]  feed_pool_b_o,
    output logic                                             feed_frame_done_o
);

    localparam int PIX_W = NUM_FILT * OPERAND_WDTH;
    localparam int WIN_W = PIX_W * NUM_PIXELS_BUF;
    localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int GRP_W = (NUM_PIXELS_BUF > 1) ? $clog2(NUM_PIXELS_BUF) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_PIXELS_BUF - 1);

    localparam logic [0:0] S_EVEN = 1'b0;
    localparam logic [0:0] S_ODD  = 1'b1;

    logic [0:0]       state_r;
    logic [COL_W-1:0] col_cnt_r;
    logic [ROW_W-1:0] row_cnt_r;
    logic [GRP_W-1:0] grp_cnt_r;
    logic [PIX_W-1:0] linebuf_r [ROW_LEN];
    logic [PIX_W-1:0] grp_r [NUM_PIXELS_BUF-1];

    logic             valid_r;
    logic [WIN_W-1:0] pool_a_r;
    logic [WIN_W-1:0] pool_b_r;
    logic             frame_done_r;

    logic             ready_s;
    logic             accept_s;
    logic             col_last_s;
    logic             load_s;
    logic [WIN_W-1:0] win_a_s;
    logic [WIN_W-1:0] win_b_s;

    // Line-buffer column of pixel p in the segment ending at col; clamped so that
    // non-load cycles never address outside the buffer.
    function automatic logic [COL_W-1:0] seg_col(input logic [COL_W-1:0] col, input int p);
        int idx;
        idx = int'(col) - (NUM_PIXELS_BUF - 1) + p;
        if (idx < 0) begin
            return {COL_W{1'b0}};
        end else begin
            return COL_W'(idx);
        end
    endfunction

    // Input backpressure: only the window-completing odd beat can stall.
    always_comb begin
        if ((state_r == S_ODD) && (grp_cnt_r == GRP_LAST)) begin
            ready_s = !valid_r || feed_out_ready_i;
        end else begin
            ready_s = 1'b1;
        end
    end

    assign accept_s   = feed_in_valid_i && ready_s;
    assign col_last_s = (col_cnt_r == COL_LAST);
    assign load_s     = accept_s && (state_r == S_ODD) && (grp_cnt_r == GRP_LAST);

    // Assemble the candidate window: even-row segment from the line buffer, odd-row
    // segment from the group registers plus the pixel arriving now.
    always_comb begin
        win_a_s = {WIN_W{1'b0}};
        win_b_s = {WIN_W{1'b0}};
        for (int f = 0; f < NUM_FILT; f++) begin
            for (int p = 0; p < NUM_PIXELS_BUF; p++) begin
                win_a_s[(f*NUM_PIXELS_BUF+p)*OPERAND_WDTH +: OPERAND_WDTH] =
                    linebuf_r[seg_col(col_cnt_r, p)][f*OPERAND_WDTH +: OPERAND_WDTH];
            end
            for (int p = 0; p < NUM_PIXELS_BUF - 1; p++) begin
                win_b_s[(f*NUM_PIXELS_BUF+p)*OPERAND_WDTH +: OPERAND_WDTH] =
                    grp_r[p][f*OPERAND_WDTH +: OPERAND_WDTH];
            end
            win_b_s[(f*NUM_PIXELS_BUF+NUM_PIXELS_BUF-1)*OPERAND_WDTH +: OPERAND_WDTH] =
                feed_in_pix_i[f*OPERAND_WDTH +: OPERAND_WDTH];
        end
    end

    // Position counters and even/odd row phase.
    always_ff @(posedge conv1_feed_clk or negedge conv1_feed_rst_b) begin
        if (!conv1_feed_rst_b) begin
            state_r   <= S_EVEN;
            col_cnt_r <= {COL_W{1'b0}};
            row_cnt_r <= {ROW_W{1'b0}};
            grp_cnt_r <= {GRP_W{1'b0}};
        end else if (accept_s) begin
            col_cnt_r <= col_last_s ? {COL_W{1'b0}} : (col_cnt_r + COL_W'(1));
            case (state_r)
                S_EVEN: begin
                    grp_cnt_r <= {GRP_W{1'b0}};
                    if (col_last_s) begin
                        row_cnt_r <= row_cnt_r + ROW_W'(1);
                        state_r   <= S_ODD;
                    end else begin
                        row_cnt_r <= row_cnt_r;
                        state_r   <= S_EVEN;
                    end
                end
                S_ODD: begin
                    grp_cnt_r <= (grp_cnt_r == GRP_LAST) ? {GRP_W{1'b0}} : (grp_cnt_r + GRP_W'(1));
                    if (col_last_s) begin
                        row_cnt_r <= (row_cnt_r == ROW_LAST) ? {ROW_W{1'b0}} : (row_cnt_r + ROW_W'(1));
                        state_r   <= S_EVEN;
                    end else begin
                        row_cnt_r <= row_cnt_r;
                        state_r   <= S_ODD;
                    end
                end
                default: begin
                    state_r   <= S_EVEN;
                    col_cnt_r <= {COL_W{1'b0}};
                    row_cnt_r <= {ROW_W{1'b0}};
                    grp_cnt_r <= {GRP_W{1'b0}};
                end
            endcase
        end
    end

    // Even-row line buffer; contents are don't-care until rewritten, so no reset.
    always_ff @(posedge conv1_feed_clk) begin
        if (accept_s && (state_r == S_EVEN)) begin
            linebuf_r[col_cnt_r] <= feed_in_pix_i;
        end
    end

    // Odd-row partial segment, excluding the window-completing pixel.
    always_ff @(posedge conv1_feed_clk or negedge conv1_feed_rst_b) begin
        if (!conv1_feed_rst_b) begin
            for (int i = 0; i < NUM_PIXELS_BUF - 1; i++) begin
                grp_r[i] <= {PIX_W{1'b0}};
            end
        end else if (accept_s && (state_r == S_ODD) && (grp_cnt_r != GRP_LAST)) begin
            grp_r[grp_cnt_r] <= feed_in_pix_i;
        end
    end

    // Output window registers: a load on the handshake edge keeps valid high.
    always_ff @(posedge conv1_feed_clk or negedge conv1_feed_rst_b) begin
        if (!conv1_feed_rst_b) begin
            valid_r      <= 1'b0;
            pool_a_r     <= {WIN_W{1'b0}};
            pool_b_r     <= {WIN_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            if (load_s) begin
                valid_r  <= 1'b1;
                pool_a_r <= win_a_s;
                pool_b_r <= win_b_s;
            end else if (feed_out_ready_i) begin
                valid_r  <= 1'b0;
            end
            frame_done_r <= load_s && col_last_s && (row_cnt_r == ROW_LAST);
        end
    end

    assign feed_in_ready_o   = ready_s;
    assign feed_out_valid_o  = valid_r;
    assign feed_pool_a_o     = pool_a_r;
    assign feed_pool_b_o     = pool_b_r;
    assign feed_frame_done_o = frame_done_r;

endmodule
